// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debounce input stage: FSM state encoding,
// default stability window and press-counter width.
package key_debounce_pkg;

  // Debounce FSM states. The two IDLE states hold a settled level. The two
  // WAIT states time a candidate change before it is accepted.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  // Default number of consecutive synchronised cycles a new level must hold.
  localparam int unsigned DEFAULT_STABLE_CYCLES = 1000;

  // Width of the accepted-press counter.
  localparam int unsigned PRESS_CNT_W = 8;

  // Debounced level implied by a state: high while settled high or while
  // a fall is still being qualified.
  function automatic logic level_of(input db_state_t st);
    return (st == IDLE_HIGH) || (st == WAIT_LOW);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser. It brings an asynchronous level into the CLK
// domain. Reset is synchronous and active-high, and the reset value is 0.
// The module is shared with other input stages.
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic sync1;

  // Two back-to-back flops. Only q may be used by downstream logic.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Key/switch debounce stage that feeds the D input of the downstream flop.
// The raw key level is synchronised, then filtered by a stability counter
// and a four-state FSM. The stage outputs a clean level and registered
// one-cycle RISE/FALL pulses.
// Optional feature: define KEY_DEBOUNCE_CNT_EN to build the 8-bit accepted
// press counter. When the macro is undefined, PRESS_CNT is tied to zero.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CW            = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   KEY_IN,
  output logic                   D_OUT,
  output logic                   RISE,
  output logic                   FALL,
  output logic [PRESS_CNT_W-1:0] PRESS_CNT
);

  // The count value on which a candidate level is accepted.
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_CYCLES - 1);

  logic          s;
  db_state_t     state;
  db_state_t     next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          rise_set;
  logic          fall_set;

  sync_2ff u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (KEY_IN),
    .q   (s)
  );

  // State, stability counter and edge-pulse registers. Reset wins over any
  // pending transition, so an interrupted WAIT never produces a pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      RISE  <= rise_set;
      FALL  <= fall_set;
    end
  end

  // Next-state logic. Any return to the old level restarts qualification
  // from zero. The counter stops at LAST_CNT because acceptance leaves the
  // WAIT state, so no saturation logic is needed.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    rise_set   = 1'b0;
    fall_set   = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s) begin
          next_state = WAIT_HIGH;
          cnt_next   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          next_state = IDLE_LOW;
          cnt_next   = '0;
        end else if (cnt == LAST_CNT) begin
          next_state = IDLE_HIGH;
          cnt_next   = '0;
          rise_set   = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          next_state = WAIT_LOW;
          cnt_next   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          next_state = IDLE_HIGH;
          cnt_next   = '0;
        end else if (cnt == LAST_CNT) begin
          next_state = IDLE_LOW;
          cnt_next   = '0;
          fall_set   = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        next_state = IDLE_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // The debounced level is decoded directly from the state register, so it
  // changes on the same edge that launches the matching pulse.
  always_comb begin
    D_OUT = level_of(state);
  end

`ifdef KEY_DEBOUNCE_CNT_EN
  logic [PRESS_CNT_W-1:0] press_cnt_q;

  // Count accepted presses on the WAIT_HIGH to IDLE_HIGH edge. The count
  // wraps modulo 256.
  always_ff @(posedge CLK) begin
    if (RST) begin
      press_cnt_q <= '0;
    end else if (rise_set) begin
      press_cnt_q <= press_cnt_q + PRESS_CNT_W'(1);
    end
  end

  assign PRESS_CNT = press_cnt_q;
`else
  assign PRESS_CNT = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with STABLE_CYCLES=4. The stimulus
// process pushes the expected pulse (level, count and arrival cycle) into a
// queue. The monitor pops and compares each time RISE or FALL is seen. A
// pulse with nothing queued is a failure.
// Honours KEY_DEBOUNCE_CNT_EN for the expected PRESS_CNT value.
module tb_key_debounce;

  localparam int STABLE = 4;
  localparam int LAT    = STABLE + 3;
  localparam int SETTLE = LAT + 2;

  typedef struct {
    logic       rise;
    logic       fall;
    logic       d_out;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic       KEY_IN;
  logic       D_OUT;
  logic       RISE;
  logic       FALL;
  logic [7:0] PRESS_CNT;

  int         compared;
  int         mismatched;
  int         cycle;
  logic [7:0] press_model;
  exp_t       exp_q[$];
  exp_t       mon_e;

  key_debounce #(
    .STABLE_CYCLES (STABLE),
    .CW            (16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .KEY_IN    (KEY_IN),
    .D_OUT     (D_OUT),
    .RISE      (RISE),
    .FALL      (FALL),
    .PRESS_CNT (PRESS_CNT)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Count rising edges so that pulse arrival can be checked to the cycle.
  initial cycle = 0;
  always @(posedge CLK) cycle <= cycle + 1;

  // Compare one value, record it, and report any difference.
  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Expected PRESS_CNT for the current build.
  function automatic int expCnt();
`ifdef KEY_DEBOUNCE_CNT_EN
    return int'(press_model);
`else
    return 0;
`endif
  endfunction

  // Drive a clean, held level change and queue the pulse it must produce.
  task automatic applyStimulus(input logic key);
    exp_t e;
    KEY_IN = key;
    if (key) press_model = press_model + 8'd1;
    e.rise  = key;
    e.fall  = ~key;
    e.d_out = key;
    e.cnt   = 8'(expCnt());
    e.cyc   = cycle + LAT;
    exp_q.push_back(e);
    repeat (SETTLE) @(negedge CLK);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RISE || FALL) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_pulse: got RISE=%0b FALL=%0b at cycle %0d, expected no pulse",
                 RISE, FALL, cycle);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("pulse_rise", int'(RISE), int'(mon_e.rise));
        checkOutput("pulse_fall", int'(FALL), int'(mon_e.fall));
        checkOutput("pulse_d_out", int'(D_OUT), int'(mon_e.d_out));
        checkOutput("pulse_press_cnt", int'(PRESS_CNT), int'(mon_e.cnt));
        checkOutput("pulse_cycle", cycle, mon_e.cyc);
      end
    end
  end

  // Watchdog that stops a run which never finishes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    compared    = 0;
    mismatched  = 0;
    press_model = 8'd0;
    RST         = 1'b1;
    KEY_IN      = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_d_out", int'(D_OUT), 0);
    checkOutput("reset_rise", int'(RISE), 0);
    checkOutput("reset_fall", int'(FALL), 0);
    checkOutput("reset_press_cnt", int'(PRESS_CNT), 0);
    RST = 1'b0;

    // Key held low: nothing may change.
    repeat (20) @(negedge CLK);
    checkOutput("idle_low_d_out", int'(D_OUT), 0);
    checkOutput("idle_low_press_cnt", int'(PRESS_CNT), 0);

    // Clean press, then clean release.
    applyStimulus(1'b1);
    checkOutput("press_d_out", int'(D_OUT), 1);
    applyStimulus(1'b0);
    checkOutput("release_d_out", int'(D_OUT), 0);
    checkOutput("release_press_cnt", int'(PRESS_CNT), expCnt());

    // Bounce: three high cycles, then low, five times.
    for (int i = 0; i < 5; i++) begin
      KEY_IN = 1'b1;
      repeat (3) @(negedge CLK);
      KEY_IN = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("bounce_d_out", int'(D_OUT), 0);
    end
    repeat (SETTLE) @(negedge CLK);
    checkOutput("bounce_press_cnt", int'(PRESS_CNT), expCnt());

    // Reset while in WAIT_HIGH with cnt=2: the pending rise is abandoned.
    KEY_IN = 1'b1;
    repeat (5) @(negedge CLK);
    checkOutput("wait_high_d_out", int'(D_OUT), 0);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("mid_reset_d_out", int'(D_OUT), 0);
    checkOutput("mid_reset_rise", int'(RISE), 0);
    checkOutput("mid_reset_fall", int'(FALL), 0);
    checkOutput("mid_reset_press_cnt", int'(PRESS_CNT), 0);
    press_model = 8'd0;
    RST = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b0);

    // 256 clean presses starting from zero wrap the counter back to zero.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    press_model = 8'd0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1);
      applyStimulus(1'b0);
    end
    checkOutput("wrap_press_cnt", int'(PRESS_CNT), expCnt());
    checkOutput("wrap_model_zero", int'(press_model), 0);

    repeat (SETTLE) @(negedge CLK);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Input-conditioning stage that sits directly upstream of the synchronous D flip-flop stage and drives its D input. Synchronises a raw asynchronous key/switch level into the CLK domain, rejects bounce with a stability counter and state machine, and presents a clean level plus single-cycle edge pulses. Optionally counts accepted presses.

## Interface
- STABLE_CYCLES, 1000: consecutive synchronised cycles a new level must hold before acceptance; legal range 2..65535.
- CW, 16: stability counter width; must satisfy 2**CW > STABLE_CYCLES.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous and active-high.
- KEY_IN  input  1  raw asynchronous key level, may bounce.
- D_OUT  output  1  debounced level; connects to the downstream flip-flop's D.
- RISE  output  1  one-cycle pulse when D_OUT goes 0->1.
- FALL  output  1  one-cycle pulse when D_OUT goes 1->0.
- PRESS_CNT  output  8  count of accepted rising edges; wraps.

## Operation
- Synchroniser: two flops, sync1 <= KEY_IN, s <= sync1. The FSM uses only s.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. D_OUT is 1 in IDLE_HIGH and WAIT_LOW, and 0 otherwise.
- IDLE_LOW:
  - s==1 -> WAIT_HIGH, cnt <= 0.
  - s==0 -> stay.
- WAIT_HIGH:
  - s==0 -> IDLE_LOW, cnt <= 0 (bounce rejected, no pulse).
  - s==1 and cnt==STABLE_CYCLES-1 -> IDLE_HIGH.
  - otherwise cnt <= cnt+1.
- IDLE_HIGH and WAIT_LOW mirror IDLE_LOW and WAIT_HIGH with polarity swapped.
- RISE and FALL are registered. RISE is 1 exactly on the cycle after the WAIT_HIGH->IDLE_HIGH edge, and FALL likewise for WAIT_LOW->IDLE_LOW. Both are 0 otherwise.
- PRESS_CNT increments by 1 on the WAIT_HIGH->IDLE_HIGH edge. It is 8-bit modulo and wraps 255->0.
- The counter never exceeds STABLE_CYCLES-1, so no saturation logic is needed.

## Timing
- Reset values: sync1=0, s=0, state=IDLE_LOW, cnt=0, D_OUT=0, RISE=0, FALL=0, PRESS_CNT=0.
- RST has priority over every transition at the same edge. Reset during WAIT_* abandons the pending change, and no pulse is produced.
- Latency: the edge that first samples a new stable KEY_IN is edge 0. D_OUT, the matching pulse and the PRESS_CNT update all appear after edge STABLE_CYCLES+2.
- Bounce shorter than STABLE_CYCLES synchronised cycles never changes D_OUT. Each return to the old level restarts the count from 0.
- Minimum spacing between a RISE and the next FALL is STABLE_CYCLES+1 cycles, so RISE and FALL are never asserted together.
- KEY_IN held at 1 through reset release: D_OUT rises STABLE_CYCLES+2 edges after the first edge with RST=0. No spurious FALL occurs.

## Configuration
- KEY_DEBOUNCE_CNT_EN defined: the PRESS_CNT register and incrementer are compiled in, behaving as above.
- Undefined: PRESS_CNT is tied to 8'd0 and no counter logic exists. All other behaviour is identical.

## Structure
- Shared package key_debounce_pkg holds:
  - the FSM state typedef (2-bit enum: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW);
  - the default STABLE_CYCLES constant;
  - the PRESS_CNT width constant (8).
- One sub-module, sync_2ff (1-bit two-flop synchroniser with CLK/RST, reset value 0). It is instantiated once and reused by other input stages.

## Test plan
All scenarios use STABLE_CYCLES=4.
- Reset, then KEY_IN=0 for 20 cycles -> D_OUT, RISE, FALL and PRESS_CNT all remain 0.
- KEY_IN 0->1 sampled at edge 0 and held -> D_OUT=1 and RISE=1 after edge 6, RISE=0 after edge 7, PRESS_CNT=1.
- KEY_IN high for 3 cycles then low, repeated 5 times -> D_OUT stays 0, with no RISE and no PRESS_CNT change.
- From D_OUT=1, KEY_IN falls and holds -> FALL=1 for exactly one cycle 6 edges later, D_OUT=0, PRESS_CNT unchanged.
- RST asserted for 1 cycle while in WAIT_HIGH with cnt=2 -> next cycle state=IDLE_LOW, all outputs 0. A stable KEY_IN=1 then produces RISE 6 edges after RST deasserts.
- 256 clean presses -> PRESS_CNT wraps to 0. With KEY_DEBOUNCE_CNT_EN undefined, PRESS_CNT reads 0 throughout.
